// File: rtl/ffo6_rr_arbiter.sv
// Six-requester round-robin arbiter: rotated MSB-first find-first-one, registered one-hot grant.
// Optional grant watchdog enabled by defining FFO6_ARB_WATCHDOG_EN.
module ffo6_rr_arbiter #(
  parameter bit          FIXED_PRI = 1'b0,
  parameter int unsigned HOLD_MAX  = 200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] req_i,
  input  logic       ack_i,
  output logic [5:0] grant_o,
  output logic [2:0] grant_id_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [2:0] timeout_id_o,
  output logic       state_o
);

  // Handshake: req_i is a level held until granted; grant_o is registered one-hot;
  // ack_i is a 1-cycle pulse honoured only while a grant is active.

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] last_q;
  logic [5:0] req_rot;
  logic [3:0] rot_sum;
  logic [2:0] rr_id, win_id;
  logic       withdraw, expire, release_now;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_out_of_range
    $error("HOLD_MAX must be in 1..255");
  end

  function automatic logic [2:0] ffo6(input logic [5:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // Rotating by last puts requester last-1 at the MSB, so it wins first.
  always_comb begin
    req_rot = 6'({req_i, req_i} >> last_q);
    rot_sum = {1'b0, ffo6(req_rot)} + {1'b0, last_q};
    rr_id   = (rot_sum >= 4'd6) ? 3'(rot_sum - 4'd6) : rot_sum[2:0];
    win_id  = FIXED_PRI ? ffo6(req_i) : rr_id;
  end

  assign withdraw = ~|(req_i & grant_o);

  always_comb begin
    state_d     = state_q;
    release_now = 1'b0;
    case (state_q)
      IDLE:    if (|req_i) state_d = GRANT;
      GRANT: begin
        release_now = ack_i | withdraw | expire;
        if (release_now) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_o    <= 6'd0;
      grant_id_o <= 3'd7;
      last_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GRANT) begin
        grant_o    <= 6'd1 << win_id;
        grant_id_o <= win_id;
      end else if (release_now) begin
        grant_o    <= 6'd0;
        grant_id_o <= 3'd7;
        last_q     <= grant_id_o;
      end
    end
  end

`ifdef FFO6_ARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] wd_cnt_q;

  // An ack or withdraw in the expiry cycle takes precedence over the timeout.
  assign expire = (state_q == GRANT) && (wd_cnt_q == HOLD_LAST) && !ack_i && !withdraw;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q     <= 8'd0;
      timeout_o    <= 1'b0;
      timeout_id_o <= 3'd7;
    end else begin
      wd_cnt_q  <= (state_q == GRANT) ? wd_cnt_q + 8'd1 : 8'd0;
      timeout_o <= expire;
      if (expire) timeout_id_o <= grant_id_o;
    end
  end
`else
  assign expire       = 1'b0;
  assign timeout_o    = 1'b0;
  assign timeout_id_o = 3'd7;
`endif

  assign busy_o  = |grant_o;
  assign state_o = state_q;

endmodule

// File: tb/tb_ffo6_rr_arbiter.sv
// Bench for ffo6_rr_arbiter: directed spec scenarios plus random traffic against a
// priority-list reference model; a second FIXED_PRI=1 instance covers fixed priority.
module tb_ffo6_rr_arbiter;

  localparam int HOLD = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ack, f_ack;
  logic [5:0] req, f_req;
  logic [5:0] g, f_g;
  logic [2:0] gid, tid, f_gid, f_tid;
  logic       busy, tout, st, f_busy, f_tout, f_st;

  ffo6_rr_arbiter #(.FIXED_PRI(1'b0), .HOLD_MAX(HOLD)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ack_i(ack),
    .grant_o(g), .grant_id_o(gid), .busy_o(busy),
    .timeout_o(tout), .timeout_id_o(tid), .state_o(st));

  ffo6_rr_arbiter #(.FIXED_PRI(1'b1), .HOLD_MAX(200)) dut_fixed (
    .clk_i(clk), .rst_i(rst), .req_i(f_req), .ack_i(f_ack),
    .grant_o(f_g), .grant_id_o(f_gid), .busy_o(f_busy),
    .timeout_o(f_tout), .timeout_id_o(f_tid), .state_o(f_st));

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  // reference model state
  bit m_gr, m_to;
  int m_gid, m_last, m_tid, m_cnt;

  // Order after a win by k is k-1, k-2, ..., k (mod 6).
  function automatic int pick(input logic [5:0] r, input int last);
    for (int p = 1; p <= 6; p++) begin
      if (r[(last + 6 - p) % 6]) return (last + 6 - p) % 6;
    end
    return 7;
  endfunction

  task automatic model_next();
    bit rel, exp_now;
    exp_now = 1'b0;
    if (rst) begin
      m_gr = 0; m_gid = 7; m_last = 0; m_to = 0; m_tid = 7; m_cnt = 0;
    end else if (!m_gr) begin
      m_to = 0;
      if (|req) begin
        m_gr = 1; m_gid = pick(req, m_last); m_cnt = 0;
      end
    end else begin
      rel = ack || !req[m_gid];
`ifdef FFO6_ARB_WATCHDOG_EN
      exp_now = !rel && (m_cnt == HOLD - 1);
`endif
      m_to = exp_now;
      if (exp_now) m_tid = m_gid;
      if (rel || exp_now) begin
        m_last = m_gid; m_gid = 7; m_gr = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_main();
    chk("grant", {2'b0, g}, m_gr ? 8'(1 << m_gid) : 8'd0);
    chk("grant_id", {5'b0, gid}, 8'(m_gid));
    chk("busy", {7'b0, busy}, {7'b0, m_gr});
    chk("state", {7'b0, st}, {7'b0, m_gr});
    chk("timeout", {7'b0, tout}, {7'b0, m_to});
    chk("timeout_id", {5'b0, tid}, 8'(m_tid));
  endtask

  // driver: inputs are set #1 after an edge; the model consumes them before the next edge
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_main();
  endtask

  int n_fixed;

  initial begin
    rst = 1'b1; req = 6'h3F; ack = 1'b0; f_req = 6'h00; f_ack = 1'b0;
    m_gr = 0; m_gid = 7; m_last = 0; m_to = 0; m_tid = 7; m_cnt = 0;
    #1;

    // reset held two cycles with all requesting
    step(); chk("rst_busy", {7'b0, busy}, 8'd0);
    step(); chk("rst_id", {5'b0, gid}, 8'd7);
    rst = 1'b0;

    // rotation 5,4,3,2,1,0,5 with an idle cycle between grants
    exp_q = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    step(); chk("first_id", {5'b0, gid}, {5'b0, exp_q.pop_front()});
    repeat (6) begin
      ack = 1'b1; step(); chk("idle_gap", {7'b0, busy}, 8'd0);
      ack = 1'b0; step(); chk("rot_id", {5'b0, gid}, {5'b0, exp_q.pop_front()});
    end
    ack = 1'b1; step();
    ack = 1'b0; req = 6'h00; step();

    // skip: last=3, req 100001 -> 0 then 5
    req = 6'b001000; step(); chk("skip_pre", {5'b0, gid}, 8'd3);
    ack = 1'b1; step();
    ack = 1'b0; req = 6'b100001; step(); chk("skip_id0", {5'b0, gid}, 8'd0);
    ack = 1'b1; step();
    ack = 1'b0; step(); chk("skip_id5", {5'b0, gid}, 8'd5);
    ack = 1'b1; step();
    ack = 1'b0; req = 6'h00; step();

    // withdraw of id 2, then last=2 makes 1 beat 3
    req = 6'b000100; step(); chk("wd_id2", {5'b0, gid}, 8'd2);
    req = 6'b000000; step();
    chk("withdraw_rel", {7'b0, busy}, 8'd0);
    chk("withdraw_to", {7'b0, tout}, 8'd0);
    req = 6'b001010; step(); chk("after_withdraw", {5'b0, gid}, 8'd1);
    ack = 1'b1; step();
    ack = 1'b0; req = 6'h00; step();

    // watchdog / indefinite hold on id 1
    req = 6'b000010; step(); chk("hold_id1", {5'b0, gid}, 8'd1);
`ifdef FFO6_ARB_WATCHDOG_EN
    repeat (HOLD - 1) step();
    chk("hold_busy", {7'b0, busy}, 8'd1);
    step();
    chk("timeout_pulse", {7'b0, tout}, 8'd1);
    chk("timeout_id1", {5'b0, tid}, 8'd1);
    req = 6'h00; step();
    chk("timeout_once", {7'b0, tout}, 8'd0);
`else
    repeat (300) step();
    chk("hold_300", {7'b0, busy}, 8'd1);
    chk("hold_no_to", {7'b0, tout}, 8'd0);
    req = 6'h00; step();
`endif

    // random traffic against the model
    repeat (600) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = 6'($urandom_range(0, 63));
      ack = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0; req = 6'h00; ack = 1'b0;
    step(); step();

    // fixed priority: id 4 always beats id 1
    n_fixed = 0;
    f_req = 6'b010010;
    repeat (30) begin
      f_ack = f_busy;
      @(posedge clk);
      #1;
      if (f_busy) begin
        n_fixed++;
        chk("fixed_id4", {5'b0, f_gid}, 8'd4);
      end
      chk("fixed_no1", {7'b0, f_g[1]}, 8'd0);
    end
    chk("fixed_grants", 8'(n_fixed), 8'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
